// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cpu_ctrl_fsm
// Description : Multicycle control unit for the 16-bit CPU datapath.
//               Sequences fetch/decode/execute/memory/writeback and drives the
//               datapath mux selects plus PC/IR/regfile/memory strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_ctrl_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_instr,
    input  logic        i_zero,
    input  logic        i_mem_ready,
    output logic        o_addr_sel,
    output logic [1:0]  o_alu_b_sel,
    output logic [1:0]  o_wb_sel,
    output logic [1:0]  o_pc_src,
    output logic [1:0]  o_alu_op,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_reg_we,
    output logic        o_mem_re,
    output logic        o_mem_we,
    output logic        o_illegal,
    output logic        o_halted,
    output logic [3:0]  o_state
);

    localparam logic [3:0] c_FETCH    = 4'd0;
    localparam logic [3:0] c_DECODE   = 4'd1;
    localparam logic [3:0] c_EXEC     = 4'd2;
    localparam logic [3:0] c_WB       = 4'd3;
    localparam logic [3:0] c_MEM_ADDR = 4'd4;
    localparam logic [3:0] c_MEM_RD   = 4'd5;
    localparam logic [3:0] c_LW_WB    = 4'd6;
    localparam logic [3:0] c_MEM_WR   = 4'd7;
    localparam logic [3:0] c_BRANCH   = 4'd8;
    localparam logic [3:0] c_JUMP     = 4'd9;
    localparam logic [3:0] c_HALT     = 4'd10;

    localparam logic [1:0] c_ALU_ADD  = 2'd0;
    localparam logic [1:0] c_ALU_SUB  = 2'd1;

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    logic [3:0] w_opcode;
    logic       w_is_rtype, w_is_addi, w_is_lw, w_is_sw, w_is_beq;
    logic       w_is_jmp, w_is_jal, w_is_hlt, w_is_legal;
    logic [1:0] w_exec_b_sel, w_exec_op;
    logic       w_addr_sel, w_ir_we, w_pc_we, w_reg_we, w_mem_re, w_mem_we;
    logic       w_illegal, w_halted;
    logic [1:0] w_alu_b_sel, w_wb_sel, w_pc_src, w_alu_op;
    logic       w_unused;

    // Opcode classification; the low 12 instruction bits belong to the datapath
    assign w_opcode   = i_instr[15:12];
    assign w_unused   = ^i_instr[11:0];
    assign w_is_rtype = (w_opcode[3:2] == 2'b00);
    assign w_is_addi  = (w_opcode == 4'h4);
    assign w_is_lw    = (w_opcode == 4'h5);
    assign w_is_sw    = (w_opcode == 4'h6);
    assign w_is_beq   = (w_opcode == 4'h7);
    assign w_is_jmp   = (w_opcode == 4'h8);
    assign w_is_jal   = (w_opcode == 4'h9);
    assign w_is_hlt   = (w_opcode == 4'hF);
    assign w_is_legal = w_is_rtype | w_is_addi | w_is_lw | w_is_sw | w_is_beq |
                        w_is_jmp | w_is_jal | w_is_hlt;

    // EXEC and WB share the ALU setup so the ALU result stays stable into WB
    assign w_exec_b_sel = w_is_addi ? 2'd1 : 2'd0;
    assign w_exec_op    = w_is_rtype ? w_opcode[1:0] : c_ALU_ADD;

    // State register: reset always lands in FETCH
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Per-state output decode and next-state selection
    always_comb begin
        w_next_state = r_state;
        w_addr_sel   = 1'b0;
        w_alu_b_sel  = 2'd0;
        w_wb_sel     = 2'd0;
        w_pc_src     = 2'd0;
        w_alu_op     = c_ALU_ADD;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_reg_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_illegal    = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_mem_re = 1'b1;
                if (i_mem_ready) begin
                    w_ir_we      = 1'b1;
                    w_pc_we      = 1'b1;
                    w_next_state = c_DECODE;
                end
            end
            c_DECODE: begin
                if (w_is_rtype || w_is_addi)    w_next_state = c_EXEC;
                else if (w_is_lw || w_is_sw)    w_next_state = c_MEM_ADDR;
                else if (w_is_beq)              w_next_state = c_BRANCH;
                else if (w_is_jmp || w_is_jal)  w_next_state = c_JUMP;
                else if (w_is_hlt)              w_next_state = c_HALT;
                else                            w_next_state = c_FETCH;
                w_illegal = ~w_is_legal;
            end
            c_EXEC: begin
                w_alu_b_sel  = w_exec_b_sel;
                w_alu_op     = w_exec_op;
                w_next_state = c_WB;
            end
            c_WB: begin
                w_alu_b_sel  = w_exec_b_sel;
                w_alu_op     = w_exec_op;
                w_reg_we     = 1'b1;
                w_next_state = c_FETCH;
            end
            c_MEM_ADDR: begin
                w_alu_b_sel  = 2'd1;
                w_next_state = w_is_lw ? c_MEM_RD : c_MEM_WR;
            end
            c_MEM_RD: begin
                w_mem_re   = 1'b1;
                w_addr_sel = 1'b1;
                if (i_mem_ready) w_next_state = c_LW_WB;
            end
            c_LW_WB: begin
                w_reg_we     = 1'b1;
                w_wb_sel     = 2'd1;
                w_next_state = c_FETCH;
            end
            c_MEM_WR: begin
                w_mem_we   = 1'b1;
                w_addr_sel = 1'b1;
                if (i_mem_ready) w_next_state = c_FETCH;
            end
            c_BRANCH: begin
                w_alu_op     = c_ALU_SUB;
                w_pc_we      = i_zero;
                w_pc_src     = i_zero ? 2'd1 : 2'd0;
                w_next_state = c_FETCH;
            end
            c_JUMP: begin
                w_pc_we      = 1'b1;
                w_pc_src     = 2'd2;
                // JAL links the PC that FETCH already incremented
                w_reg_we     = w_is_jal;
                w_wb_sel     = w_is_jal ? 2'd2 : 2'd0;
                w_next_state = c_FETCH;
            end
            c_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next_state = c_FETCH;
            end
        endcase
    end

    // Strobes are squashed during reset so an aborted access never commits
    assign o_ir_we     = w_ir_we   & ~rst;
    assign o_pc_we     = w_pc_we   & ~rst;
    assign o_reg_we    = w_reg_we  & ~rst;
    assign o_mem_re    = w_mem_re  & ~rst;
    assign o_mem_we    = w_mem_we  & ~rst;
    assign o_illegal   = w_illegal & ~rst;
    assign o_halted    = w_halted  & ~rst;
    assign o_addr_sel  = w_addr_sel;
    assign o_alu_b_sel = w_alu_b_sel;
    assign o_wb_sel    = w_wb_sel;
    assign o_pc_src    = w_pc_src;
    assign o_alu_op    = w_alu_op;
    assign o_state     = r_state;

endmodule
`default_nettype wire

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multicycle control unit for the 16-bit CPU datapath. It sequences fetch, decode, execute, memory and writeback through a Moore-style state machine. It drives the select lines of the datapath's 2-, 3- and 4-input 16-bit muxes, plus the PC, IR, register-file and memory enables. Memory accesses use a ready handshake, so wait states stretch only the FETCH, MEM_RD and MEM_WR states.

## Interface
Parameters: none; widths fixed by the 16-bit ISA.
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- instr  in  16  IR contents; opcode = instr[15:12]
- zero  in  1  ALU zero flag, combinational from current ALU inputs
- mem_ready  in  1  memory completes the current access this cycle
- addr_sel  out  1  address mux_2: 0 = PC, 1 = ALU result
- alu_b_sel  out  2  ALU B mux_4: 0 = register B, 1 = sign-extended imm, 2 = const 1, 3 = zero-extended imm
- wb_sel  out  2  writeback mux_3: 0 = ALU result register, 1 = memory data, 2 = PC
- pc_src  out  2  PC mux_3: 0 = PC+1, 1 = branch target, 2 = jump target
- alu_op  out  2  0 ADD, 1 SUB, 2 AND, 3 OR
- ir_we, pc_we, reg_we, mem_re, mem_we  out  1 each  write/access strobes
- illegal  out  1  one-cycle pulse on an undefined opcode
- halted  out  1  high in HALT
- state  out  4  current state encoding, for debug

## Operation
Opcodes:
- 0–3: R-type; alu_op = opcode[1:0]
- 4: ADDI
- 5: LW
- 6: SW
- 7: BEQ
- 8: JMP
- 9: JAL
- F: HLT
- others: illegal

State encodings and actions:
- FETCH (0): mem_re = 1, addr_sel = 0. If mem_ready: ir_we = 1, pc_we = 1, pc_src = 0, go to DECODE; otherwise hold.
- DECODE (1): instr is valid here. Next state by opcode:
  - R-type or ADDI → EXEC
  - LW or SW → MEM_ADDR
  - BEQ → BRANCH
  - JMP or JAL → JUMP
  - HLT → HALT
  - illegal → FETCH, with illegal = 1 in this cycle
- EXEC (2): alu_b_sel = 0 and alu_op = opcode[1:0] for R-type; alu_b_sel = 1 and alu_op = ADD for ADDI. Go to WB.
- WB (3): reg_we = 1, wb_sel = 0; alu_op and alu_b_sel hold their EXEC values. Go to FETCH.
- MEM_ADDR (4): alu_b_sel = 1, alu_op = ADD. LW → MEM_RD, SW → MEM_WR.
- MEM_RD (5): mem_re = 1, addr_sel = 1. If mem_ready → LW_WB; otherwise hold.
- LW_WB (6): reg_we = 1, wb_sel = 1. Go to FETCH.
- MEM_WR (7): mem_we = 1, addr_sel = 1. If mem_ready → FETCH; otherwise hold.
- BRANCH (8): alu_op = SUB, alu_b_sel = 0. If zero: pc_we = 1, pc_src = 1. Always go to FETCH.
- JUMP (9): pc_we = 1, pc_src = 2. For JAL also reg_we = 1, wb_sel = 2, writing the already-incremented PC. Go to FETCH.
- HALT (10): halted = 1. Terminal; only rst leaves it.

Default output values: every strobe 0, every select 0, alu_op ADD. A signal not listed for a state takes its default.

## Timing
- Outputs decode combinationally from state, except the strobes gated by mem_ready (FETCH ir_we/pc_we, MEM_RD/MEM_WR exit) and zero (BRANCH pc_we). Those are Mealy-gated in the same cycle.
- rst sampled high: state becomes FETCH at that edge. While rst = 1, ir_we, pc_we, reg_we, mem_re, mem_we, illegal and halted are forced to 0 combinationally.
- Outputs at reset: state = 0, halted = 0, illegal = 0, all selects 0, alu_op 0. After the reset edge, FETCH drives mem_re = 1 once rst drops.
- Cycles per instruction with zero-wait memory (mem_ready held high):
  - R-type / ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - JMP / JAL: 3
  - illegal: 2
  - Each memory wait cycle adds 1.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR. zero is ignored outside BRANCH.
- mem_re and mem_we are never high in the same cycle. No strobe is asserted in DECODE, EXEC or MEM_ADDR.
- rst asserted mid-access (e.g. during a stalled MEM_WR): the strobe drops in that cycle. The next cycle is FETCH with no write completed. The memory model must tolerate an aborted access.
- instr must stay stable from DECODE until the instruction returns to FETCH. The IR is written only in FETCH.

## Test plan
- R-type, zero-wait: reset, then instr = 0x1123 (SUB), mem_ready = 1 → states 0,1,2,3,0. In EXEC, alu_op = 1 and alu_b_sel = 0. In WB only, reg_we = 1 with wb_sel = 0. Total 4 cycles.
- LW with 2 wait cycles: instr = 0x5xxx, mem_ready low for 2 cycles in MEM_RD → MEM_RD lasts 3 cycles with mem_re = 1, addr_sel = 1. LW_WB then asserts reg_we = 1, wb_sel = 1. No mem_we at any time.
- BEQ: instr = 0x7xxx, run once with zero = 1 and once with zero = 0. Taken: BRANCH asserts pc_we = 1, pc_src = 1. Not taken: pc_we = 0. Both return to FETCH after 3 cycles.
- JAL vs JMP: 0x9xxx asserts pc_we, pc_src = 2, reg_we, wb_sel = 2 in JUMP. 0x8xxx asserts the same with reg_we = 0.
- Illegal and halt: instr = 0xA000 gives illegal = 1 for exactly the DECODE cycle, then FETCH. instr = 0xF000 enters HALT with halted = 1 and no strobes for 20 cycles. rst then gives state = 0, halted = 0.
- Reset mid-SW: mem_ready = 0 in MEM_WR, rst pulsed for 1 cycle → mem_we = 0 during rst, state = 0 afterwards, then normal fetch resumes.
